// File: rtl/ext_mem_access_seq.sv
`default_nettype none
// ============================================================================
// ext_mem_access_seq : Avalon-MM sequencer running timed byte read/write cycles
//                      on the external memory bus.   Rev 1.0
// ============================================================================
module ext_mem_access_seq #(
    parameter int ADDR_W     = 16,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_dout,
    output logic              ext_dout_en,
    input  logic [7:0]        ext_din,
    output logic              ext_oe_n,
    output logic              ext_we_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int c_MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                               ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                               ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    // Counter only ever holds (cycles - 1), so $clog2(max) bits suffice.
    localparam int c_CNT_W = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'(HOLD_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_is_wr;
    logic                w_is_wr_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic [7:0]          r_rdata;
    logic                r_done;
    logic                r_err;
    logic [31:0]         w_rd_mux;

    logic w_wr, w_ctrl_wr, w_start_rd, w_start_wr, w_busy;
    logic w_accept, w_reject, w_clear, w_cnt_zero, w_last_hold;
    logic w_unused_ok;

    assign w_wr        = ~write_n;
    assign w_ctrl_wr   = w_wr && (address == 2'd3);
    assign w_start_rd  = writedata[0];
    assign w_start_wr  = writedata[1];
    assign w_clear     = w_ctrl_wr && writedata[2];
    assign w_busy      = (r_state != S_IDLE);
    assign w_accept    = w_ctrl_wr && !w_busy && (w_start_rd ^ w_start_wr);
    assign w_reject    = w_ctrl_wr && ((w_start_rd && w_start_wr) ||
                                       (w_busy && (w_start_rd || w_start_wr)));
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_last_hold = (r_state == S_HOLD) && w_cnt_zero;
    assign w_unused_ok = &{1'b0, writedata[31:ADDR_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_is_wr <= w_is_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_is_wr_nxt = r_is_wr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_is_wr_nxt = w_start_wr;
                end
            end
            S_SETUP:  if (w_cnt_zero) w_state_nxt = S_STROBE;
            S_STROBE: if (w_cnt_zero) w_state_nxt = S_HOLD;
            S_HOLD:   if (w_cnt_zero) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // Reload on every state entry, otherwise count down to zero.
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_SETUP:  w_cnt_nxt = c_SETUP_LD;
                S_STROBE: w_cnt_nxt = c_STROBE_LD;
                S_HOLD:   w_cnt_nxt = c_HOLD_LD;
                default:  w_cnt_nxt = '0;
            endcase
        end else if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_comb begin
        case (address)
            2'd0:    w_rd_mux = {24'd0, r_rdata};
            2'd1:    w_rd_mux = 32'(r_addr);
            2'd2:    w_rd_mux = {24'd0, r_wdata};
            default: w_rd_mux = {29'd0, r_err, r_done, w_busy};
        endcase
    end

    // Bus pins are registered from the next state so strobes are glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_oe_n    <= 1'b1;
            ext_we_n    <= 1'b1;
            ext_dout_en <= 1'b0;
            ext_addr    <= '0;
            ext_dout    <= '0;
        end else begin
            ext_oe_n    <= !((w_state_nxt == S_STROBE) && !w_is_wr_nxt);
            ext_we_n    <= !((w_state_nxt == S_STROBE) && w_is_wr_nxt);
            ext_dout_en <= (w_state_nxt != S_IDLE) && w_is_wr_nxt;
            if (w_accept) begin
                ext_addr <= r_addr;
                ext_dout <= r_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
            if (w_wr && !w_busy && (address == 2'd1))
                r_addr <= writedata[ADDR_W-1:0];
            if (w_wr && !w_busy && (address == 2'd2))
                r_wdata <= writedata[7:0];
            if ((r_state == S_STROBE) && w_cnt_zero && !r_is_wr)
                r_rdata <= ext_din;
            // Clear is applied first so a same-write start or reject still lands.
            if (w_clear || w_accept)
                r_done <= 1'b0;
            if (w_last_hold)
                r_done <= 1'b1;
            if (w_clear)
                r_err <= 1'b0;
            if (w_reject)
                r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_access_seq.sv
`default_nettype none
// ============================================================================
// tb_ext_mem_access_seq : randomized self-checking bench for ext_mem_access_seq
//                         Rev 1.0
// ============================================================================
module tb_ext_mem_access_seq;

    localparam int SETUP  = 1;
    localparam int STROBE = 2;
    localparam int HOLD   = 1;
    localparam int TOTAL  = SETUP + STROBE + HOLD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  ext_din = 8'd0;
    wire  [31:0] readdata;
    wire  [15:0] ext_addr;
    wire  [7:0]  ext_dout;
    wire         ext_dout_en;
    wire         ext_oe_n;
    wire         ext_we_n;

    ext_mem_access_seq #(
        .ADDR_W(16), .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .ext_addr(ext_addr),
        .ext_dout(ext_dout), .ext_dout_en(ext_dout_en), .ext_din(ext_din),
        .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register contents and flags as software sees them.
    logic [15:0] m_addr, m_ext_addr;
    logic [7:0]  m_wdata, m_rdata, m_ext_dout;
    bit          m_done, m_err;

    task automatic model_reset();
        m_addr = 0; m_ext_addr = 0; m_wdata = 0; m_rdata = 0; m_ext_dout = 0;
        m_done = 0; m_err = 0;
    endtask

    // Net effect of a CTRL write issued while idle, observed after completion.
    task automatic model_cmd(input logic [2:0] c);
        if (c[2]) begin m_done = 0; m_err = 0; end
        if (c[0] ^ c[1]) begin
            m_ext_addr = m_addr;
            m_ext_dout = m_wdata;
            if (c[0]) m_rdata = ext_din;
            m_done = 1;
        end else if (c[0] && c[1]) begin
            m_err = 1;
        end
    endtask

    function automatic logic [31:0] m_status();
        return {29'd0, m_err, m_done, 1'b0};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // Observe the bus for n cycles; busy is taken from STATUS reads only.
    task automatic watch(input int n, input logic [15:0] ea, input logic [7:0] ed,
                         output int oe, output int we, output int en,
                         output int busy, output int bad);
        logic [1:0] pa;
        oe = 0; we = 0; en = 0; busy = 0; bad = 0;
        pa = address;
        for (int i = 0; i < n; i++) begin
            if (!ext_oe_n) oe++;
            if (!ext_we_n) we++;
            if (ext_dout_en) en++;
            if (pa == 2'd3 && readdata[0]) busy++;
            if (ext_addr !== ea || ext_dout !== ed) bad++;
            @(posedge clk);
            pa = address;
            @(negedge clk);
        end
    endtask

    task automatic do_xfer(input logic [31:0] cmd, output int oe, output int we,
                           output int en, output int busy, output int bad);
        model_cmd(cmd[2:0]);
        wr(2'd3, cmd);
        watch(10, m_ext_addr, m_ext_dout, oe, we, en, busy, bad);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (ext_oe_n !== 1'b1) begin n_err++; $display("FAIL rst_oe_n got=%0b exp=1", ext_oe_n); end
        n_vec++; if (ext_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n got=%0b exp=1", ext_we_n); end
        n_vec++; if (ext_dout_en !== 1'b0) begin n_err++; $display("FAIL rst_dout_en got=%0b exp=0", ext_dout_en); end
        n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL rst_readdata got=%0h exp=0", readdata); end
        n_vec++; if (ext_addr !== 16'd0) begin n_err++; $display("FAIL rst_ext_addr got=%0h exp=0", ext_addr); end
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd3, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_status got=%0h exp=0", d); end
        rd(2'd0, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_rdata got=%0h exp=0", d); end
    endtask

    task automatic test_read();
        int oe, we, en, busy, bad;
        logic [31:0] d;
        wr(2'd1, 32'h1234); m_addr = 16'h1234;
        ext_din = 8'hA5;
        do_xfer(32'h1, oe, we, en, busy, bad);
        n_vec++; if (busy !== TOTAL) begin n_err++; $display("FAIL rd_busy got=%0d exp=%0d", busy, TOTAL); end
        n_vec++; if (oe !== STROBE) begin n_err++; $display("FAIL rd_oe got=%0d exp=%0d", oe, STROBE); end
        n_vec++; if (we !== 0 || en !== 0) begin n_err++; $display("FAIL rd_we_en got=%0d/%0d exp=0/0", we, en); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rd_bus got=%0d exp=0", bad); end
        rd(2'd3, d);
        n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL rd_status got=%0h exp=%0h", d, m_status()); end
        rd(2'd0, d);
        n_vec++; if (d !== {24'd0, m_rdata}) begin n_err++; $display("FAIL rd_rdata got=%0h exp=%0h", d, m_rdata); end
    endtask

    task automatic test_write();
        int oe, we, en, busy, bad;
        logic [31:0] d;
        wr(2'd1, 32'h00FF); m_addr = 16'h00FF;
        wr(2'd2, 32'h3C);   m_wdata = 8'h3C;
        do_xfer(32'h2, oe, we, en, busy, bad);
        n_vec++; if (en !== TOTAL) begin n_err++; $display("FAIL wr_en got=%0d exp=%0d", en, TOTAL); end
        n_vec++; if (we !== STROBE) begin n_err++; $display("FAIL wr_we got=%0d exp=%0d", we, STROBE); end
        n_vec++; if (oe !== 0) begin n_err++; $display("FAIL wr_oe got=%0d exp=0", oe); end
        n_vec++; if (busy !== TOTAL) begin n_err++; $display("FAIL wr_busy got=%0d exp=%0d", busy, TOTAL); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL wr_bus got=%0d exp=0", bad); end
        rd(2'd3, d);
        n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL wr_status got=%0h exp=%0h", d, m_status()); end
    endtask

    task automatic test_start_while_busy();
        int oe, we, en, busy, bad;
        logic [31:0] d;
        wr(2'd3, 32'h4); model_cmd(3'b100);
        ext_din = 8'h5A;
        model_cmd(3'b001);
        wr(2'd3, 32'h1);
        fork
            watch(10, m_ext_addr, m_ext_dout, oe, we, en, busy, bad);
            begin @(negedge clk); wr(2'd3, 32'h1); end
        join
        m_err = 1;
        n_vec++; if (oe !== STROBE) begin n_err++; $display("FAIL swb_oe got=%0d exp=%0d", oe, STROBE); end
        n_vec++; if (busy !== TOTAL) begin n_err++; $display("FAIL swb_busy got=%0d exp=%0d", busy, TOTAL); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL swb_bus got=%0d exp=0", bad); end
        rd(2'd3, d);
        n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL swb_status got=%0h exp=%0h", d, m_status()); end
        rd(2'd0, d);
        n_vec++; if (d !== {24'd0, m_rdata}) begin n_err++; $display("FAIL swb_rdata got=%0h exp=%0h", d, m_rdata); end
        wr(2'd3, 32'h4); model_cmd(3'b100);
        rd(2'd3, d);
        n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL swb_clear got=%0h exp=%0h", d, m_status()); end
    endtask

    task automatic test_illegal();
        int oe, we, en, busy, bad;
        logic [31:0] d;
        do_xfer(32'h3, oe, we, en, busy, bad);
        n_vec++; if (oe + we + en !== 0) begin n_err++; $display("FAIL ill_strobe got=%0d exp=0", oe + we + en); end
        n_vec++; if (busy !== 0) begin n_err++; $display("FAIL ill_busy got=%0d exp=0", busy); end
        rd(2'd3, d);
        n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL ill_status got=%0h exp=%0h", d, m_status()); end
        ext_din = 8'hC3;
        do_xfer(32'h5, oe, we, en, busy, bad);
        n_vec++; if (oe !== STROBE || busy !== TOTAL) begin n_err++; $display("FAIL clr_start got=%0d/%0d exp=%0d/%0d", oe, busy, STROBE, TOTAL); end
        rd(2'd3, d);
        n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL clr_start_status got=%0h exp=%0h", d, m_status()); end
    endtask

    task automatic test_reg_lock();
        int oe, we, en, busy, bad;
        logic [31:0] d;
        wr(2'd1, 32'hBEEF); m_addr = 16'hBEEF;
        wr(2'd2, 32'h77);   m_wdata = 8'h77;
        model_cmd(3'b010);
        wr(2'd3, 32'h2);
        fork
            watch(10, m_ext_addr, m_ext_dout, oe, we, en, busy, bad);
            begin @(negedge clk); wr(2'd1, 32'h1111); wr(2'd2, 32'h22); end
        join
        n_vec++; if (en !== TOTAL || we !== STROBE) begin n_err++; $display("FAIL lock_xfer got=%0d/%0d exp=%0d/%0d", en, we, TOTAL, STROBE); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL lock_bus got=%0d exp=0", bad); end
        rd(2'd1, d);
        n_vec++; if (d !== {16'd0, m_addr}) begin n_err++; $display("FAIL lock_addr got=%0h exp=%0h", d, m_addr); end
        rd(2'd2, d);
        n_vec++; if (d !== {24'd0, m_wdata}) begin n_err++; $display("FAIL lock_wdata got=%0h exp=%0h", d, m_wdata); end
    endtask

    task automatic test_random();
        int oe, we, en, busy, bad, r;
        logic [31:0] d, a, w, cmd;
        bit acc, isrd, iswr;
        for (int it = 0; it < 20; it++) begin
            a = $urandom; w = $urandom;
            wr(2'd1, a); m_addr = a[15:0];
            wr(2'd2, w); m_wdata = w[7:0];
            rd(2'd1, d);
            n_vec++; if (d !== {16'd0, m_addr}) begin n_err++; $display("FAIL rnd_addr got=%0h exp=%0h", d, m_addr); end
            rd(2'd2, d);
            n_vec++; if (d !== {24'd0, m_wdata}) begin n_err++; $display("FAIL rnd_wdata got=%0h exp=%0h", d, m_wdata); end
            r = $urandom_range(0, 7);
            cmd = $urandom;
            cmd[1:0] = (r == 0) ? 2'b11 : ((r < 4) ? 2'b01 : 2'b10);
            ext_din = 8'($urandom);
            isrd = (cmd[1:0] == 2'b01);
            iswr = (cmd[1:0] == 2'b10);
            acc = isrd || iswr;
            do_xfer(cmd, oe, we, en, busy, bad);
            n_vec++; if (oe !== (isrd ? STROBE : 0)) begin n_err++; $display("FAIL rnd_oe it=%0d got=%0d", it, oe); end
            n_vec++; if (we !== (iswr ? STROBE : 0)) begin n_err++; $display("FAIL rnd_we it=%0d got=%0d", it, we); end
            n_vec++; if (en !== (iswr ? TOTAL : 0)) begin n_err++; $display("FAIL rnd_en it=%0d got=%0d", it, en); end
            n_vec++; if (busy !== (acc ? TOTAL : 0)) begin n_err++; $display("FAIL rnd_busy it=%0d got=%0d", it, busy); end
            n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rnd_bus it=%0d got=%0d exp=0", it, bad); end
            rd(2'd3, d);
            n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL rnd_status it=%0d got=%0h exp=%0h", it, d, m_status()); end
            rd(2'd0, d);
            n_vec++; if (d !== {24'd0, m_rdata}) begin n_err++; $display("FAIL rnd_rdata it=%0d got=%0h exp=%0h", it, d, m_rdata); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            wr(2'd1, 32'hABCD);
            wr(2'd2, 32'h99);
            wr(2'd3, (k == 0) ? 32'h1 : 32'h2);
            @(negedge clk);
            n_vec++; if ((k == 0 ? ext_oe_n : ext_we_n) !== 1'b0) begin n_err++; $display("FAIL mid_strobe k=%0d got=1 exp=0", k); end
            #2 reset_n = 1'b0;
            #1;
            n_vec++; if (ext_oe_n !== 1'b1 || ext_we_n !== 1'b1) begin n_err++; $display("FAIL mid_rst_strobe got=%0b%0b exp=11", ext_oe_n, ext_we_n); end
            n_vec++; if (ext_dout_en !== 1'b0 || ext_addr !== 16'd0 || ext_dout !== 8'd0) begin n_err++; $display("FAIL mid_rst_bus got=%0b/%0h/%0h exp=0/0/0", ext_dout_en, ext_addr, ext_dout); end
            @(negedge clk);
            reset_n = 1'b1;
            model_reset();
            rd(2'd3, d);
            n_vec++; if (d !== m_status()) begin n_err++; $display("FAIL mid_status got=%0h exp=%0h", d, m_status()); end
            rd(2'd0, d);
            n_vec++; if (d !== {24'd0, m_rdata}) begin n_err++; $display("FAIL mid_rdata got=%0h exp=%0h", d, m_rdata); end
            rd(2'd1, d);
            n_vec++; if (d !== {16'd0, m_addr}) begin n_err++; $display("FAIL mid_addr got=%0h exp=%0h", d, m_addr); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read();
        test_write();
        test_start_while_busy();
        test_illegal();
        test_reg_lock();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
